// File: rtl/md_ctrl_pkg.sv
// Shared constants and FSM state type for the X-stage multiply/divide controller.
package md_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int unsigned RSTATUS_MUL_DFLT = 4;
  localparam int unsigned RSTATUS_DIV_DFLT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_op_decode.sv
// Combinational detection of valid R-type mul/div instructions in the X stage.
module md_op_decode
  import md_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [4:0] alu_op_i,
  input  logic       ex_valid_i,
  output logic       is_mul_o,
  output logic       is_div_o
);

  logic rtype;

  assign rtype    = ex_valid_i && (opcode_i == OP_RTYPE);
  assign is_mul_o = rtype && (alu_op_i == ALU_MUL);
  assign is_div_o = rtype && (alu_op_i == ALU_DIV);

endmodule

// File: rtl/multdiv_controller.sv
// Multi-cycle multiply/divide sequencer: start pulse, pipeline stall, one-cycle writeback.
// Optional watchdog enabled by defining MD_TIMEOUT_EN.
module multdiv_controller
  import md_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 40,
  parameter int unsigned RSTATUS_MUL = RSTATUS_MUL_DFLT,
  parameter int unsigned RSTATUS_DIV = RSTATUS_DIV_DFLT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        md_wb_en,
  output logic        rstatus_we,
  output logic [31:0] rstatus_val
);

  md_state_e state_q, state_d;
  logic      is_mul, is_div, issue, timeout_hit;
  logic      op_is_div_q, exc_q;

  md_op_decode u_decode (
    .opcode_i   (opcode),
    .alu_op_i   (alu_op),
    .ex_valid_i (ex_valid),
    .is_mul_o   (is_mul),
    .is_div_o   (is_div)
  );

  assign issue = (is_mul || is_div) && !flush;

`ifdef MD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && issue) begin
      cnt_q <= '0;
    end else if (state_q == BUSY && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_is_div_q <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && issue) begin
        op_is_div_q <= is_div;
        exc_q       <= 1'b0;
      end else if (state_q == BUSY && !flush) begin
        // A ready result beats the watchdog in the same cycle.
        if (md_result_rdy) begin
          exc_q <= md_exception;
        end else if (timeout_hit) begin
          exc_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = BUSY;
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (md_result_rdy || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_mult   = 1'b0;
    ctrl_div    = 1'b0;
    stall       = 1'b0;
    md_wb_en    = 1'b0;
    rstatus_we  = 1'b0;
    rstatus_val = '0;
    unique case (state_q)
      IDLE: begin
        ctrl_mult = issue && is_mul;
        ctrl_div  = issue && is_div;
        stall     = issue;
      end
      BUSY: stall = 1'b1;
      DONE: begin
        md_wb_en   = 1'b1;
        rstatus_we = exc_q;
        if (exc_q) begin
          rstatus_val = {27'd0, op_is_div_q ? 5'(RSTATUS_DIV) : 5'(RSTATUS_MUL)};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed table-driven bench for multdiv_controller plus multi-cycle corner sequences.
module tb_multdiv_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  opcode, alu_op;
  logic        ex_valid, flush, md_result_rdy, md_exception;
  logic        ctrl_mult, ctrl_div, stall, md_wb_en, rstatus_we;
  logic [31:0] rstatus_val;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] F_MUL = 5'b10000;
  localparam logic [4:0] F_DIV = 5'b01000;
  localparam logic [4:0] F_STL = 5'b00100;
  localparam logic [4:0] F_WB  = 5'b00010;
  localparam logic [4:0] F_WE  = 5'b00001;
  localparam logic [4:0] F_0   = 5'b00000;

  typedef struct {
    logic       ev;
    logic [4:0] op;
    logic [4:0] alu;
    logic       fl;
    logic       rdy;
    logic       exc;
    logic [4:0] exp_flags;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[19];

  multdiv_controller #(
    .TIMEOUT     (40),
    .RSTATUS_MUL (4),
    .RSTATUS_DIV (5)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .flush         (flush),
    .md_result_rdy (md_result_rdy),
    .md_exception  (md_exception),
    .ctrl_mult     (ctrl_mult),
    .ctrl_div      (ctrl_div),
    .stall         (stall),
    .md_wb_en      (md_wb_en),
    .rstatus_we    (rstatus_we),
    .rstatus_val   (rstatus_val)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic ev, logic [4:0] op, logic [4:0] alu, logic fl,
                              logic rdy, logic exc, logic [4:0] f, logic [31:0] v);
    vec_t r;
    r.ev = ev; r.op = op; r.alu = alu; r.fl = fl; r.rdy = rdy; r.exc = exc;
    r.exp_flags = f; r.exp_val = v;
    return r;
  endfunction

  function automatic logic [4:0] flags();
    return {ctrl_mult, ctrl_div, stall, md_wb_en, rstatus_we};
  endfunction

  task automatic chk(input string name, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [4:0] f, input logic [31:0] v);
    chk(name, {flags(), rstatus_val}, {f, v});
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic drive(input logic ev, input logic [4:0] op, input logic [4:0] alu,
                       input logic fl, input logic rdy, input logic exc);
    @(negedge clock);
    ex_valid = ev; opcode = op; alu_op = alu; flush = fl;
    md_result_rdy = rdy; md_exception = exc;
    #1;
  endtask

  initial begin
    int n_stl, n_mul, n_wb, n_we;
    reset_n = 1'b0; ex_valid = 1'b0; opcode = '0; alu_op = '0;
    flush = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0;

    vecs[0]  = mk(0, 5'd0, 5'd6, 0, 0, 0, F_0,           32'd0);
    vecs[1]  = mk(1, 5'd1, 5'd6, 0, 0, 0, F_0,           32'd0);
    vecs[2]  = mk(1, 5'd0, 5'd5, 0, 0, 0, F_0,           32'd0);
    vecs[3]  = mk(1, 5'd0, 5'd6, 1, 0, 0, F_0,           32'd0);
    vecs[4]  = mk(1, 5'd0, 5'd6, 0, 0, 0, F_MUL | F_STL, 32'd0);
    vecs[5]  = mk(1, 5'd0, 5'd6, 0, 0, 0, F_STL,         32'd0);
    vecs[6]  = mk(1, 5'd0, 5'd6, 0, 1, 1, F_STL,         32'd0);
    vecs[7]  = mk(1, 5'd0, 5'd6, 0, 1, 1, F_WB | F_WE,   32'd4);
    vecs[8]  = mk(1, 5'd0, 5'd7, 0, 0, 0, F_DIV | F_STL, 32'd0);
    vecs[9]  = mk(1, 5'd0, 5'd7, 0, 1, 0, F_STL,         32'd0);
    vecs[10] = mk(1, 5'd0, 5'd7, 0, 0, 0, F_WB,          32'd0);
    vecs[11] = mk(0, 5'd0, 5'd7, 0, 1, 1, F_0,           32'd0);
    vecs[12] = mk(1, 5'd0, 5'd7, 0, 0, 0, F_DIV | F_STL, 32'd0);
    vecs[13] = mk(1, 5'd0, 5'd7, 1, 1, 1, F_STL,         32'd0);
    vecs[14] = mk(0, 5'd0, 5'd0, 0, 0, 0, F_0,           32'd0);
    vecs[15] = mk(1, 5'd0, 5'd7, 0, 0, 0, F_DIV | F_STL, 32'd0);
    vecs[16] = mk(1, 5'd0, 5'd7, 0, 1, 1, F_STL,         32'd0);
    vecs[17] = mk(1, 5'd0, 5'd7, 0, 0, 0, F_WB | F_WE,   32'd5);
    vecs[18] = mk(0, 5'd0, 5'd0, 0, 0, 0, F_0,           32'd0);

    @(negedge clock); #1;
    chk_out("reset_outputs", F_0, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ev, vecs[i].op, vecs[i].alu, vecs[i].fl, vecs[i].rdy, vecs[i].exc);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_flags, vecs[i].exp_val);
    end

    // mul, ready 17 cycles after issue, no exception.
    n_stl = 0; n_mul = 0; n_wb = 0; n_we = 0;
    for (int c = 0; c < 25; c++) begin
      drive(c <= 18, 5'd0, 5'd6, 0, c == 17, 0);
      n_stl += int'(stall); n_mul += int'(ctrl_mult);
      n_wb  += int'(md_wb_en); n_we += int'(rstatus_we);
      if (c == 0)  chk_out("mul17_issue", F_MUL | F_STL, 32'd0);
      if (c == 18) chk_out("mul17_done", F_WB, 32'd0);
    end
    chk("mul17_stall_cycles", 37'(n_stl), 37'd18);
    chk("mul17_mult_pulses",  37'(n_mul), 37'd1);
    chk("mul17_wb_pulses",    37'(n_wb),  37'd1);
    chk("mul17_rstatus_we",   37'(n_we),  37'd0);

    // Hung unit: the result never becomes ready.
    n_stl = 0;
`ifdef MD_TIMEOUT_EN
    for (int c = 0; c < 46; c++) begin
      drive(c <= 41, 5'd0, 5'd6, 0, 0, 0);
      n_stl += int'(stall);
      if (c == 41) chk_out("hang_watchdog_done", F_WB | F_WE, 32'd4);
      if (c == 42) chk_out("hang_after_done", F_0, 32'd0);
    end
    chk("hang_stall_cycles", 37'(n_stl), 37'd41);
`else
    for (int c = 0; c < 46; c++) begin
      drive(1, 5'd0, 5'd6, 0, 0, 0);
      n_stl += int'(stall);
    end
    chk("hang_stall_cycles", 37'(n_stl), 37'd46);
    drive(1, 5'd0, 5'd6, 1, 0, 0);
    chk_out("hang_flush_cycle", F_STL, 32'd0);
    drive(0, 5'd0, 5'd0, 0, 0, 0);
    chk_out("hang_after_flush", F_0, 32'd0);
`endif

    // Asynchronous reset while BUSY on a divide.
    drive(1, 5'd0, 5'd7, 0, 0, 0);
    chk_out("rst_issue_div", F_DIV | F_STL, 32'd0);
    drive(1, 5'd0, 5'd7, 0, 0, 0);
    drive(1, 5'd0, 5'd7, 0, 0, 0);
    chk_out("rst_busy", F_STL, 32'd0);
    #2;
    reset_n = 1'b0; ex_valid = 1'b0;
    #1;
    chk_out("rst_async_clear", F_0, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(0, 5'd0, 5'd7, 0, c == 1, 1);
      chk_out($sformatf("rst_post_idle%0d", c), F_0, 32'd0);
    end
    drive(1, 5'd0, 5'd6, 0, 0, 0);
    chk_out("rst_reissue_mul", F_MUL | F_STL, 32'd0);
    drive(1, 5'd0, 5'd6, 0, 1, 0);
    chk_out("rst_reissue_busy", F_STL, 32'd0);
    drive(1, 5'd0, 5'd6, 0, 0, 0);
    chk_out("rst_reissue_done", F_WB, 32'd0);
    drive(0, 5'd0, 5'd0, 0, 0, 0);
    chk_out("final_idle", F_0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
